// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, buffers returned words with their
// addresses in a small FIFO, and discards responses to fetches squashed by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;

  localparam logic [3:0] DEPTH_W  = 4'(DEPTH);
  localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [31:0] data_q [4];
  logic [31:0] addr_q [4];

  logic        pop_s, acc_s, rsp_s, keep_s;
  logic [2:0]  rsp_dec_s;
  logic [31:0] rsp_pc_s;
  logic        unused_s;

  assign unused_s    = ^redirect_pc[1:0];
  assign instr_valid = rst_n && (cnt_q != 3'd0);
  assign instr       = instr_valid ? data_q[rd_q] : 32'd0;
  assign instr_pc    = instr_valid ? addr_q[rd_q] : 32'd0;
  assign pop_s       = instr_valid && instr_ready;

  // A slot freed by this cycle's pop can already be claimed, which sustains one fetch per cycle.
  assign imem_req_valid = rst_n && (state_q != BOOT) && !redirect_valid &&
                          (({1'b0, outst_q} + {1'b0, cnt_q} - {3'd0, pop_s}) < DEPTH_W);
  assign imem_addr = pc_q;
  assign acc_s     = imem_req_valid && imem_req_ready;
  assign rsp_s     = imem_rsp_valid && (outst_q != 3'd0);
  assign keep_s    = rsp_s && (drop_q == 3'd0) && !redirect_valid;
  assign rsp_dec_s = outst_q - {2'd0, rsp_s};
  // Kept fetches are contiguous and end at pc-4, so the oldest one sits at pc - 4*outstanding.
  assign rsp_pc_s  = pc_q - {27'd0, outst_q, 2'b00};

  // Next-state computation for pc, counters, FIFO pointers and FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    outst_d = rsp_dec_s + {2'd0, acc_s};
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = rsp_dec_s;
      cnt_d  = 3'd0;
      rd_d   = 2'd0;
      wr_d   = 2'd0;
      if ((state_q == FLUSH) || (rsp_dec_s != 3'd0)) begin
        state_d = FLUSH;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (acc_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (rsp_s && (drop_q != 3'd0)) begin
        drop_d = drop_q - 3'd1;
      end else begin
        drop_d = drop_q;
      end
      if (pop_s) begin
        rd_d = (rd_q == LAST_PTR) ? 2'd0 : rd_q + 2'd1;
      end else begin
        rd_d = rd_q;
      end
      if (keep_s) begin
        wr_d = (wr_q == LAST_PTR) ? 2'd0 : wr_q + 2'd1;
      end else begin
        wr_d = wr_q;
      end
      cnt_d = cnt_q + {2'd0, keep_s} - {2'd0, pop_s};
      case (state_q)
        BOOT:    state_d = RUN;
        FLUSH:   state_d = (drop_d == 3'd0) ? RUN : FLUSH;
        default: state_d = state_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      outst_q <= 3'd0;
      drop_q  <= 3'd0;
      cnt_q   <= 3'd0;
      rd_q    <= 2'd0;
      wr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // FIFO storage; contents are only observable through the count-gated outputs.
  always_ff @(posedge clk) begin
    if (rst_n && keep_s) begin
      data_q[wr_q] <= imem_rsp_data;
      addr_q[wr_q] <= rsp_pc_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready = 1'b0;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int ep; int cyc; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

  req_t        mq[$];
  ent_t        expq[$];
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  int          n_vec = 0, n_err = 0;
  int          mem_prob = 100, rr_prob = 100, cycle = 0, epoch = 0, outst = 0;
  bit          force_rsp = 1'b0, in_boot = 1'b1;
  logic [31:0] mpc = RPC;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rstv, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit   rsp, exp_iv, pop, exp_rv;
    int   occ;
    req_t m;
    @(negedge clk);
    rst_n = rstv; instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    imem_req_ready = ($urandom_range(99) < rr_prob);
    rsp = (mq.size() > 0) && (mq[0].cyc < cycle) && (force_rsp || ($urandom_range(99) < mem_prob));
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mq[0].data : $urandom();
    #1;
    exp_iv = rstv && (expq.size() > 0);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_iv});
    if (exp_iv) begin
      chk("instr", instr, expq[0].data);
      chk("instr_pc", instr_pc, expq[0].addr);
    end else if (!rstv || in_boot) begin
      chk("instr_zero", instr, 32'd0);
      chk("instr_pc_zero", instr_pc, 32'd0);
    end
    pop = exp_iv && rdy;
    occ = outst + expq.size() - int'(pop);
    exp_rv = rstv && !in_boot && !redir && (occ < DEPTH);
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    if (exp_rv) chk("imem_addr", imem_addr, mpc);
    if (rsp) m = mq.pop_front();
    if (!rstv) begin
      mpc = RPC; outst = 0; expq.delete(); epoch++; in_boot = 1'b1;
    end else begin
      in_boot = 1'b0;
      if (pop) void'(expq.pop_front());
      if (rsp && outst > 0) begin
        outst--;
        if (!redir && m.ep == epoch) expq.push_back('{addr: m.addr, data: m.data});
      end
      if (exp_rv && imem_req_ready) begin
        mq.push_back('{addr: mpc, data: $urandom(), ep: epoch, cyc: cycle});
        acc_log.push_back(mpc); acc_cyc.push_back(cycle);
        outst++; mpc = mpc + 32'd4;
      end
      if (redir) begin
        expq.delete(); epoch++; mpc = {rpc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    cycle++;
  endtask

  task automatic do_reset();
    force_rsp = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    force_rsp = 1'b0;
  endtask

  task automatic fill2();
    mem_prob = 0; rr_prob = 100;
    for (int i = 0; i < 10 && outst < 2; i++) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    if (outst != 2) begin
      n_vec++; n_err++;
      $error("FAIL fill2: observed %0d outstanding expected 2", outst);
    end
  endtask

  task automatic wait_iv(input string tag, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      #1;
      seen = instr_valid;
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    if (seen) chk(tag, instr_pc, exp_pc);
  endtask

  initial begin
    // Reset values and basic streaming with a one-cycle memory.
    do_reset();
    acc_log.delete(); acc_cyc.delete();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("stream_a0", acc_log[0], 32'h0);
    chk("stream_a1", acc_log[1], 32'h4);
    chk("stream_a2", acc_log[2], 32'h8);
    chk("stream_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    chk("stream_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);

    // Backpressure: buffer fills, requests stop, draining resumes in order.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    #1;
    chk("full_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("full_valid", {31'd0, instr_valid}, 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect with two fetches in flight: both dropped.
    do_reset();
    mem_prob = 100;
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    fill2();
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    mem_prob = 100;
    wait_iv("redir_flush", 32'h0000_0100);

    // Redirect in the same cycle as a response.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    fill2();
    force_rsp = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    force_rsp = 1'b0; mem_prob = 100;
    wait_iv("redir_rsp", 32'h0000_0040);

    // Target alignment and address wrap.
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    #1;
    chk("align", imem_addr, 32'h0000_0200);
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    acc_log.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap0", acc_log[0], 32'hFFFF_FFFC);
    chk("wrap1", acc_log[1], 32'h0000_0000);

    // Reset with two fetches in flight; late responses ignored.
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0800);
    fill2();
    force_rsp = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    force_rsp = 1'b0; mem_prob = 100;
    wait_iv("reset_late", RPC);

    // Randomized traffic.
    rr_prob = 70; mem_prob = 60;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else if ($urandom_range(19) == 0) begin
        cyc(1'b1, ($urandom_range(3) != 0), 1'b1,
            ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom());
      end else begin
        cyc(1'b1, ($urandom_range(3) != 0), 1'b0, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
